// File: rtl/mem_wb_pipe.sv
`timescale 1ns/1ps
// mem_wb_pipe: MEM->WB pipeline of DEPTH register stages with forwarding lookup and occupancy count.
// Latency: DEPTH clock edges from input beat to write-back outputs (no freeze/flush).
// Backpressure: none; freeze holds every stage and drops the input, flush bubbles every stage.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid, WB_EN, MEM_R   incoming instruction flags
//   ALU_res, data_mem, dest  incoming payload
//   freeze, flush            pipeline hold / bubble-all controls (flush wins)
//   src1, src2               forwarding query register indices
//   WB_EN_out, WB_value,     write-back view of the oldest stage
//   dest_out
//   fwdN_hit, fwdN_val       forwarding results from registered stages only
//   occupancy                registered count of valid stages
module mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              WB_EN,
  input  logic              MEM_R,
  input  logic [DATA_W-1:0] ALU_res,
  input  logic [DATA_W-1:0] data_mem,
  input  logic [REG_W-1:0]  dest,
  input  logic              freeze,
  input  logic              flush,
  input  logic [REG_W-1:0]  src1,
  input  logic [REG_W-1:0]  src2,
  output logic              WB_EN_out,
  output logic [DATA_W-1:0] WB_value,
  output logic [REG_W-1:0]  dest_out,
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd1_val,
  output logic [DATA_W-1:0] fwd2_val,
  output logic [2:0]        occupancy
);

  typedef struct packed {
    logic              valid;
    logic              wb_en;
    logic              mem_r;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] data_mem;
    logic [REG_W-1:0]  dest;
  } stage_t;

  stage_t     stg [DEPTH];
  stage_t     nxt [DEPTH];
  logic [2:0] nxt_occ;

  function automatic logic [DATA_W-1:0] sel_val(input stage_t s);
    return s.mem_r ? s.data_mem : s.alu_res;
  endfunction

  // Next-state of a normal shift; invalid input beats become all-zero bubbles
  // so stale payload never leaks into later stages.
  always_comb begin
    nxt[0] = '0;
    if (in_valid) begin
      nxt[0].valid    = 1'b1;
      nxt[0].wb_en    = WB_EN;
      nxt[0].mem_r    = MEM_R;
      nxt[0].alu_res  = ALU_res;
      nxt[0].data_mem = data_mem;
      nxt[0].dest     = dest;
    end
    for (int k = 1; k < DEPTH; k++) begin
      nxt[k] = stg[k-1];
    end
    nxt_occ = '0;
    for (int k = 0; k < DEPTH; k++) begin
      nxt_occ = nxt_occ + {2'b00, nxt[k].valid};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) stg[k] <= '0;
      occupancy <= '0;
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) stg[k] <= '0;
      occupancy <= '0;
    end else if (!freeze) begin
      for (int k = 0; k < DEPTH; k++) stg[k] <= nxt[k];
      occupancy <= nxt_occ;
    end
  end

  assign WB_EN_out = stg[DEPTH-1].valid & stg[DEPTH-1].wb_en;
  assign WB_value  = sel_val(stg[DEPTH-1]);
  assign dest_out  = stg[DEPTH-1].dest;

  // Scan oldest to youngest so the youngest matching writer is the last to
  // assign and therefore wins.
  always_comb begin
    fwd1_hit = 1'b0;
    fwd1_val = '0;
    fwd2_hit = 1'b0;
    fwd2_val = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (stg[k].valid && stg[k].wb_en && stg[k].dest == src1) begin
        fwd1_hit = 1'b1;
        fwd1_val = sel_val(stg[k]);
      end
      if (stg[k].valid && stg[k].wb_en && stg[k].dest == src2) begin
        fwd2_hit = 1'b1;
        fwd2_val = sel_val(stg[k]);
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_pipe.sv
`timescale 1ns/1ps
// tb_mem_wb_pipe: checks four instances (DEPTH 1..4) sharing one stimulus stream
// against a history-queue model: stage k of any depth is the k-th most recent
// beat accepted since the last flush/reset, or a bubble if none.
module tb_mem_wb_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, WB_EN, MEM_R, freeze, flush;
  logic [31:0] ALU_res, data_mem;
  logic [3:0]  dest, src1, src2;

  logic        wb_en_o  [4];
  logic [31:0] wb_val_o [4];
  logic [3:0]  dest_o   [4];
  logic        h1_o     [4];
  logic        h2_o     [4];
  logic [31:0] v1_o     [4];
  logic [31:0] v2_o     [4];
  logic [2:0]  occ_o    [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_wb_pipe #(.DATA_W(32), .REG_W(4), .DEPTH(g + 1)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .WB_EN(WB_EN), .MEM_R(MEM_R),
      .ALU_res(ALU_res), .data_mem(data_mem), .dest(dest),
      .freeze(freeze), .flush(flush), .src1(src1), .src2(src2),
      .WB_EN_out(wb_en_o[g]), .WB_value(wb_val_o[g]), .dest_out(dest_o[g]),
      .fwd1_hit(h1_o[g]), .fwd2_hit(h2_o[g]), .fwd1_val(v1_o[g]), .fwd2_val(v2_o[g]),
      .occupancy(occ_o[g])
    );
  end

  typedef struct packed {
    logic        valid;
    logic        wb_en;
    logic        mem_r;
    logic [31:0] alu;
    logic [31:0] dm;
    logic [3:0]  dest;
  } beat_t;

  typedef struct packed {
    logic        wb_en;
    logic [31:0] wb_val;
    logic [3:0]  dest;
    logic        h1;
    logic [31:0] v1;
    logic        h2;
    logic [31:0] v2;
    logic [2:0]  occ;
  } view_t;

  beat_t h[$];
  int    errors = 0;
  int    checks = 0;

  function automatic beat_t stage_of(int k);
    beat_t b = '0;
    if (k < h.size()) b = h[k];
    return b;
  endfunction

  function automatic view_t expect_for(int d);
    view_t e = '0;
    beat_t last = stage_of(d - 1);
    e.wb_en  = last.valid & last.wb_en;
    e.wb_val = last.mem_r ? last.dm : last.alu;
    e.dest   = last.dest;
    for (int k = 0; k < d; k++) begin
      beat_t s = stage_of(k);
      if (s.valid) e.occ = e.occ + 3'd1;
      if (!e.h1 && s.valid && s.wb_en && s.dest == src1) begin
        e.h1 = 1'b1;
        e.v1 = s.mem_r ? s.dm : s.alu;
      end
      if (!e.h2 && s.valid && s.wb_en && s.dest == src2) begin
        e.h2 = 1'b1;
        e.v2 = s.mem_r ? s.dm : s.alu;
      end
    end
    return e;
  endfunction

  function automatic view_t dut_view(int d);
    view_t v;
    v.wb_en  = wb_en_o[d-1];
    v.wb_val = wb_val_o[d-1];
    v.dest   = dest_o[d-1];
    v.h1     = h1_o[d-1];
    v.v1     = v1_o[d-1];
    v.h2     = h2_o[d-1];
    v.v2     = v2_o[d-1];
    v.occ    = occ_o[d-1];
    return v;
  endfunction

  // One clock edge; the model applies the same edge rules to its history.
  task automatic tick();
    @(posedge clk);
    if (rst || flush) begin
      h.delete();
    end else if (!freeze) begin
      beat_t b = '0;
      if (in_valid) begin
        b.valid = 1'b1; b.wb_en = WB_EN; b.mem_r = MEM_R;
        b.alu = ALU_res; b.dm = data_mem; b.dest = dest;
      end
      h.push_front(b);
      if (h.size() > 4) void'(h.pop_back());
    end
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; WB_EN = 1'b0; MEM_R = 1'b0; freeze = 1'b0; flush = 1'b0;
    ALU_res = '0; data_mem = '0; dest = '0; src1 = '0; src2 = '0;
  endtask

  task automatic clear_pipe();
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic beat(input logic we, input logic mr, input logic [31:0] alu,
                      input logic [31:0] dm, input logic [3:0] d);
    in_valid = 1'b1; WB_EN = we; MEM_R = mr; ALU_res = alu; data_mem = dm; dest = d;
  endtask

  task automatic test_reset();
    view_t g;
    idle();
    rst = 1'b1;
    in_valid = 1'b1; WB_EN = 1'b1; ALU_res = $urandom(); dest = 4'd1; src1 = 4'd1; src2 = 4'd1;
    repeat (3) tick();
    for (int d = 1; d <= 4; d++) begin
      g = dut_view(d);
      checks++;
      if (g !== '0) begin
        errors++;
        $display("FAIL reset_state depth=%0d got=%h want=0", d, g);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    idle();
  endtask

  task automatic test_latency();
    clear_pipe();
    beat(1'b1, 1'b0, 32'h11, 32'h99, 4'd3);
    tick();
    checks++;
    if (wb_en_o[1] !== 1'b0) begin
      errors++; $display("FAIL lat_d2_edge1_wben got=%b want=0", wb_en_o[1]);
    end
    checks++;
    if ({wb_en_o[0], wb_val_o[0]} !== {1'b1, 32'h11}) begin
      errors++; $display("FAIL lat_d1_edge1 got=%b/%h want=1/00000011", wb_en_o[0], wb_val_o[0]);
    end
    idle();
    tick();
    checks++;
    if ({wb_en_o[1], wb_val_o[1], dest_o[1]} !== {1'b1, 32'h11, 4'd3}) begin
      errors++;
      $display("FAIL lat_d2_edge2 got=%b/%h/%0d want=1/00000011/3", wb_en_o[1], wb_val_o[1], dest_o[1]);
    end
    tick();
    checks++;
    if ({wb_en_o[1], wb_val_o[1], dest_o[1]} !== {1'b0, 32'h0, 4'd0}) begin
      errors++;
      $display("FAIL lat_d2_edge3_bubble got=%b/%h/%0d want=0/0/0", wb_en_o[1], wb_val_o[1], dest_o[1]);
    end
  endtask

  task automatic test_memread();
    clear_pipe();
    beat(1'b1, 1'b1, 32'h1234, 32'hABCD, 4'd2);
    tick();
    checks++;
    if ({wb_en_o[0], wb_val_o[0]} !== {1'b1, 32'hABCD}) begin
      errors++; $display("FAIL memread_sel got=%b/%h want=1/0000abcd", wb_en_o[0], wb_val_o[0]);
    end
    beat(1'b0, 1'b0, 32'h5555, 32'hABCD, 4'd9);
    tick();
    checks++;
    if ({wb_en_o[0], wb_val_o[0], dest_o[0]} !== {1'b0, 32'h5555, 4'd9}) begin
      errors++;
      $display("FAIL no_wb_fields got=%b/%h/%0d want=0/00005555/9", wb_en_o[0], wb_val_o[0], dest_o[0]);
    end
  endtask

  task automatic test_forward();
    clear_pipe();
    beat(1'b1, 1'b0, 32'hB, 32'h0, 4'd5);  tick();
    beat(1'b0, 1'b0, 32'h66, 32'h0, 4'd6); tick();
    beat(1'b1, 1'b0, 32'hA, 32'h0, 4'd5);  tick();
    // Unregistered writer to r6 on the inputs must not be forwarded.
    beat(1'b1, 1'b0, 32'h77, 32'h0, 4'd6);
    src1 = 4'd5; src2 = 4'd6;
    #1;
    checks++;
    if ({h1_o[2], v1_o[2]} !== {1'b1, 32'hA}) begin
      errors++; $display("FAIL fwd_youngest got=%b/%h want=1/0000000a", h1_o[2], v1_o[2]);
    end
    checks++;
    if ({h2_o[2], v2_o[2]} !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL fwd_nohit got=%b/%h want=0/0", h2_o[2], v2_o[2]);
    end
    checks++;
    if (occ_o[2] !== 3'd3) begin
      errors++; $display("FAIL fwd_occ got=%0d want=3", occ_o[2]);
    end
    idle();
  endtask

  task automatic test_freeze_flush();
    logic [31:0] first;
    clear_pipe();
    first = $urandom();
    beat(1'b1, 1'b0, first, 32'h0, 4'd1);      tick();
    beat(1'b1, 1'b0, $urandom(), 32'h0, 4'd2); tick();
    beat(1'b1, 1'b0, $urandom(), 32'h0, 4'd3); tick();
    for (int i = 0; i < 2; i++) begin
      beat(1'b1, 1'b1, $urandom(), $urandom(), 4'($urandom_range(0, 15)));
      freeze = 1'b1;
      tick();
      checks++;
      if ({occ_o[2], wb_en_o[2], wb_val_o[2], dest_o[2]} !== {3'd3, 1'b1, first, 4'd1}) begin
        errors++;
        $display("FAIL freeze_hold%0d got=%0d/%b/%h/%0d want=3/1/%h/1",
                 i, occ_o[2], wb_en_o[2], wb_val_o[2], dest_o[2], first);
      end
    end
    flush = 1'b1;
    tick();
    for (int d = 1; d <= 4; d++) begin
      checks++;
      if ({occ_o[d-1], wb_en_o[d-1]} !== {3'd0, 1'b0}) begin
        errors++;
        $display("FAIL freeze_flush depth=%0d got=%0d/%b want=0/0", d, occ_o[d-1], wb_en_o[d-1]);
      end
    end
    idle();
  endtask

  task automatic test_bubble();
    clear_pipe();
    in_valid = 1'b0; WB_EN = 1'b1; MEM_R = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ALU_res = $urandom(); data_mem = $urandom(); dest = 4'($urandom_range(0, 15));
      tick();
      for (int d = 1; d <= 4; d++) begin
        checks++;
        if ({wb_en_o[d-1], occ_o[d-1], wb_val_o[d-1]} !== {1'b0, 3'd0, 32'h0}) begin
          errors++;
          $display("FAIL bubble depth=%0d got=%b/%0d/%h want=0/0/0",
                   d, wb_en_o[d-1], occ_o[d-1], wb_val_o[d-1]);
        end
      end
    end
    idle();
  endtask

  task automatic test_random();
    view_t g, e;
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      WB_EN    = 1'($urandom_range(0, 3) != 0);
      MEM_R    = 1'($urandom_range(0, 1));
      ALU_res  = $urandom();
      data_mem = $urandom();
      dest     = 4'($urandom_range(0, 3));
      src1     = 4'($urandom_range(0, 3));
      src2     = 4'($urandom_range(0, 3));
      freeze   = 1'($urandom_range(0, 9) < 2);
      flush    = 1'($urandom_range(0, 24) == 0);
      tick();
      for (int d = 1; d <= 4; d++) begin
        g = dut_view(d);
        e = expect_for(d);
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL random cyc=%0d depth=%0d got=%h want=%h", i, d, g, e);
        end
      end
    end
    idle();
  endtask

  task automatic test_async_reset();
    clear_pipe();
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, 1'b0, $urandom(), 32'h0, 4'd4);
      tick();
    end
    src1 = 4'd4; src2 = 4'd4;
    checks++;
    if (occ_o[3] !== 3'd4) begin
      errors++; $display("FAIL full_before_rst got=%0d want=4", occ_o[3]);
    end
    @(negedge clk);
    #1 rst = 1'b1;
    h.delete();
    #1;
    for (int d = 1; d <= 4; d++) begin
      checks++;
      if (dut_view(d) !== '0) begin
        errors++; $display("FAIL async_rst depth=%0d got=%h want=0", d, dut_view(d));
      end
    end
    #1 rst = 1'b0;
    beat(1'b1, 1'b0, 32'h5A, 32'h0, 4'd7);
    tick();
    checks++;
    if ({wb_en_o[0], wb_val_o[0], occ_o[0], occ_o[3]} !== {1'b1, 32'h5A, 3'd1, 3'd1}) begin
      errors++;
      $display("FAIL after_rst got=%b/%h/%0d/%0d want=1/0000005a/1/1",
               wb_en_o[0], wb_val_o[0], occ_o[0], occ_o[3]);
    end
    idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_latency();
    test_memread();
    test_forward();
    test_freeze_flush();
    test_bubble();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe.md
MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

Interface
REQ-001 Parameter DATA_W, default 32, width of ALU result and memory data fields.
REQ-002 Parameter REG_W, default 4, width of destination/source register index fields.
REQ-003 Parameter DEPTH, default 1, legal range 1..4; number of register stages between input and write-back output.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  input beat carries a real instruction.
REQ-007 WB_EN, MEM_R  input  1 each  write-back enable and memory-read flag of incoming instruction.
REQ-008 ALU_res, data_mem  input  DATA_W each  ALU result and memory read data.
REQ-009 dest  input  REG_W  destination register index.
REQ-010 freeze  input  1  hold all stages.
REQ-011 flush  input  1  turn all stages into bubbles.
REQ-012 src1, src2  input  REG_W each  forwarding query indices.
REQ-013 WB_EN_out  output  1  write-back enable at last stage, gated by that stage's valid.
REQ-014 WB_value  output  DATA_W  write-back data: last stage data_mem if its MEM_R=1, else its ALU_res.
REQ-015 dest_out  output  REG_W  last-stage destination.
REQ-016 fwd1_hit, fwd2_hit  output  1 each  query matched an in-flight writer.
REQ-017 fwd1_val, fwd2_val  output  DATA_W each  forwarded value; 0 when no hit.
REQ-018 occupancy  output  3  count of valid stages, 0..DEPTH.

Function
REQ-019 Each stage SHALL hold {valid, WB_EN, MEM_R, ALU_res, data_mem, dest}; stage 0 is youngest, stage DEPTH-1 drives outputs.
REQ-020 Latency: a beat presented at edge N SHALL appear on outputs after edge N+DEPTH-1 plus one register, i.e. DEPTH clock edges, when no freeze/flush.
REQ-021 Normal edge (freeze=0, flush=0): stage 0 captures inputs with valid=in_valid; stage k captures stage k-1.
REQ-022 Input beat with in_valid=0 SHALL be stored as a bubble: valid=0, WB_EN=0, MEM_R=0, ALU_res=0, data_mem=0, dest=0.
REQ-023 freeze=1, flush=0: all stages SHALL hold value; input discarded.
REQ-024 flush=1: all stages SHALL become bubbles on that edge regardless of freeze or in_valid (flush priority over freeze).
REQ-025 WB_EN_out SHALL equal last-stage valid AND WB_EN; WB_value and dest_out reflect last-stage fields even when WB_EN_out=0.
REQ-026 Forwarding (combinational from stage registers): stage k matches srcX when valid=1, WB_EN=1, dest==srcX.
REQ-027 On multiple matches, youngest (lowest index) stage SHALL win; fwdX_val = that stage's data_mem if MEM_R=1 else ALU_res.
REQ-028 Forwarding SHALL NOT look at current input ports, only registered stages.
REQ-029 occupancy SHALL be a registered count equal to the number of stages with valid=1, updated on the same edge as the stages; 0 after flush; unchanged on freeze.
REQ-030 Register index 0 is not special; a match on dest=0 forwards like any other.

Reset
REQ-031 rst=1 SHALL asynchronously clear every stage to a bubble and occupancy to 0, independent of clk.
REQ-032 While rst=1: WB_EN_out=0, WB_value=0, dest_out=0, fwd hits 0, fwd values 0, occupancy=0.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight beats; first edge after release behaves as REQ-021.

Verification
REQ-034 DEPTH=2: beat {valid, WB_EN=1, MEM_R=0, ALU_res=0x11, dest=3} at edge 1 -> WB_EN_out=1, WB_value=0x11, dest_out=3 after edge 2, bubble after edge 3 if no new input.
REQ-035 DEPTH=1, MEM_R=1, data_mem=0xABCD, ALU_res=0x1234 -> WB_value=0xABCD.
REQ-036 DEPTH=3, stages hold dest=5 values 0xA (stage 0), 0xB (stage 2), src1=5 -> fwd1_hit=1, fwd1_val=0xA; src2=6 -> fwd2_hit=0, fwd2_val=0.
REQ-037 DEPTH=3 full, freeze=1 for 2 edges -> outputs and occupancy=3 unchanged; freeze=1 and flush=1 same edge -> occupancy=0, WB_EN_out=0.
REQ-038 Stage with WB_EN=0 and dest=src1 -> no hit; in_valid=0 with WB_EN=1 -> bubble, never WB_EN_out=1.
REQ-039 rst asserted between edges with pipe full -> outputs zero immediately, before next edge.
